alu_issue_stage: RTL and testbench

//  Producer side of the ALU control interface: decodes (aluOp, funct) into the 4-bit aluControl

---
 rtl/mips_alu_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 33 +++
 rtl/alu_issue_stage.sv | 123 ++++++++++++
 tb/tb_alu_issue_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the ALU control interface: aluOp classes, funct codes,
// aluControl codes and the issue payload layout.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam int ALU_DATA_W = 32;

    typedef struct packed {
        logic [3:0]            ctrl;
        logic [ALU_DATA_W-1:0] in1;
        logic [ALU_DATA_W-1:0] in2;
        logic                  illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluOp/funct decode into the 4-bit aluControl code; unsupported
// R-type functs fall back to add and raise illegal.
module alu_ctrl_decode
    import mips_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the op, muxes in2, and holds it in an output
// register backed by one skid entry so in_ready never depends on out_ready.
module alu_issue_stage
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_alu_src,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    // Same layout as alu_issue_t, sized by this instance's DATA_W.
    typedef struct packed {
        logic [3:0]        ctrl;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic              illegal;
    } issue_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    issue_t     new_op;

    logic       out_valid_q, out_valid_d;
    issue_t     out_op_q, out_op_d;
    logic       skid_valid_q, skid_valid_d;
    issue_t     skid_op_q, skid_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       accept;

    alu_ctrl_decode u_decode (
        .alu_op      (in_alu_op),
        .funct       (in_funct),
        .alu_control (dec_ctrl),
        .illegal     (dec_illegal)
    );

    always_comb begin
        new_op.ctrl    = dec_ctrl;
        new_op.in1     = in_rs_data;
        new_op.in2     = in_alu_src ? in_imm : in_rt_data;
        new_op.illegal = dec_illegal;
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_op_d     = out_op_q;
        skid_valid_d = skid_valid_q;
        skid_op_d    = skid_op_q;
        cnt_d        = cnt_q;

        if (accept && dec_illegal && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // A full skid implies a full output reg; nothing is accepted here.
            if (out_ready) begin
                out_op_d     = skid_op_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_op_d    = new_op;
                out_valid_d = 1'b1;
            end else begin
                skid_op_d    = new_op;
                skid_valid_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_op_q    <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_op_q     <= out_op_d;
            skid_valid_q <= skid_valid_d;
            skid_op_q    <= skid_op_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = out_op_q.ctrl;
    assign alu_in1     = out_op_q.in1;
    assign alu_in2     = out_op_q.in2;
    assign out_illegal = out_op_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with CNT_W=2 so counter saturation is reachable.
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_alu_op;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_alu_src;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic              out_illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_funct    (in_funct),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_imm      (in_imm),
        .in_alu_src  (in_alu_src),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src);
        in_valid   = v;
        in_alu_op  = op;
        in_funct   = fn;
        in_rs_data = rs;
        in_rt_data = rt;
        in_imm     = imm;
        in_alu_src = src;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_ctrl"},  64'(alu_control), 64'h0);
        chk({tag, "_in1"},   64'(alu_in1), 64'h0);
        chk({tag, "_in2"},   64'(alu_in2), 64'h0);
        chk({tag, "_ill"},   64'(out_illegal), 64'h0);
        chk({tag, "_cnt"},   64'(illegal_cnt), 64'h0);
        chk({tag, "_rdy"},   64'(in_ready), 64'h1);
    endtask

    logic [1:0]  v_op   [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [5:0]  v_fn   [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b100111, 6'b000000, 6'b000000, 6'b000000};
    logic [3:0]  v_ctrl [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                                4'b1100, 4'b0010, 4'b0110, 4'b0001};
    logic        v_src  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        chk_reset_state("por");
        reset = 1'b0;

        // First op: AND, register operands.
        drive(1'b1, 2'b10, 6'b100100, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0);
        step();
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_ctrl", 64'(alu_control), 64'h0);
        chk("t1_in1", 64'(alu_in1), 64'hF0F0);
        chk("t1_in2", 64'(alu_in2), 64'h0FF0);
        chk("t1_ill", 64'(out_illegal), 64'h0);

        // Decode table, back-to-back with out_ready=1.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, v_op[i], v_fn[i], 32'h100 + i, 32'h5, 32'h10, v_src[i]);
            step();
            chk($sformatf("dec%0d_ctrl", i), 64'(alu_control), 64'(v_ctrl[i]));
            chk($sformatf("dec%0d_in1", i), 64'(alu_in1), 64'h100 + i);
            chk($sformatf("dec%0d_in2", i), 64'(alu_in2), v_src[i] ? 64'h10 : 64'h5);
            chk($sformatf("dec%0d_vld", i), 64'(out_valid), 64'h1);
        end
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("drain_vld", 64'(out_valid), 64'h0);

        // Stall: A in output, B in skid, C held off, then ordered drain.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'h0, 32'hA, 32'h1, 32'h0, 1'b0);
        step();
        chk("stA_in1", 64'(alu_in1), 64'hA);
        chk("stA_rdy", 64'(in_ready), 64'h1);
        drive(1'b1, 2'b01, 6'h0, 32'hB, 32'h2, 32'h0, 1'b0);
        step();
        chk("stB_in1", 64'(alu_in1), 64'hA);
        chk("stB_ctrl", 64'(alu_control), 64'h2);
        chk("stB_rdy", 64'(in_ready), 64'h0);
        drive(1'b1, 2'b11, 6'h0, 32'hC, 32'h3, 32'h0, 1'b0);
        step();
        chk("stC_in1", 64'(alu_in1), 64'hA);
        chk("stC_rdy", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        step();
        chk("outB_in1", 64'(alu_in1), 64'hB);
        chk("outB_ctrl", 64'(alu_control), 64'h6);
        chk("outB_rdy", 64'(in_ready), 64'h1);
        step();
        chk("outC_in1", 64'(alu_in1), 64'hC);
        chk("outC_ctrl", 64'(alu_control), 64'h1);
        chk("outC_vld", 64'(out_valid), 64'h1);
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("outC_once", 64'(out_valid), 64'h0);

        // Flush with both entries full and an illegal op offered alongside.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'h0, 32'hD, 32'h0, 32'h0, 1'b0);
        step();
        drive(1'b1, 2'b00, 6'h0, 32'hE, 32'h0, 32'h0, 1'b0);
        step();
        chk("fl_full_rdy", 64'(in_ready), 64'h0);
        flush = 1'b1;
        drive(1'b1, 2'b10, 6'b001000, 32'hF, 32'h0, 32'h0, 1'b0);
        step();
        chk("fl_vld", 64'(out_valid), 64'h0);
        chk("fl_rdy", 64'(in_ready), 64'h1);
        chk("fl_cnt", 64'(illegal_cnt), 64'h0);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("fl_after_vld", 64'(out_valid), 64'h0);

        // Illegal funct and counter saturation at 3.
        drive(1'b1, 2'b10, 6'b001000, 32'h11, 32'h0, 32'h0, 1'b0);
        step();
        chk("ill_ctrl", 64'(alu_control), 64'h2);
        chk("ill_flag", 64'(out_illegal), 64'h1);
        chk("ill_cnt1", 64'(illegal_cnt), 64'h1);
        step();
        chk("ill_cnt2", 64'(illegal_cnt), 64'h2);
        step();
        step();
        step();
        chk("ill_sat", 64'(illegal_cnt), 64'h3);
        drive(1'b1, 2'b10, 6'b100000, 32'h12, 32'h0, 32'h0, 1'b0);
        step();
        chk("legal_ill", 64'(out_illegal), 64'h0);
        chk("legal_cnt", 64'(illegal_cnt), 64'h3);

        // Reset with both entries full.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'h0, 32'h21, 32'h7, 32'h0, 1'b0);
        step();
        drive(1'b1, 2'b11, 6'h0, 32'h22, 32'h7, 32'h0, 1'b0);
        step();
        chk("pre_rst_rdy", 64'(in_ready), 64'h0);
        reset = 1'b1;
        step();
        chk_reset_state("mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
